// File: rtl/ahb_input_stage_ble.sv
// ahb_input_stage_ble
// Per-master input stage of the BLE AHB bus matrix. Captures an address phase
// the output stage cannot take immediately, holds it until granted, and
// generates the master-side HREADYOUTS/HRESPS (wait states while pending).
// Optional build macro: AHB_INSTAGE_BURST_OVERRIDE_EN -- a held SEQ transfer
// is re-presented as NONSEQ/INCR so a burst broken by re-arbitration restarts
// cleanly at the slave.
module ahb_input_stage_ble #(
   parameter int ADDR_WIDTH = 32,
   parameter int MASTER_W   = 4
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSELS,
   input  logic [ADDR_WIDTH-1:0] HADDRS,
   input  logic [1:0]            HTRANSS,
   input  logic                  HWRITES,
   input  logic [2:0]            HSIZES,
   input  logic [2:0]            HBURSTS,
   input  logic [3:0]            HPROTS,
   input  logic [MASTER_W-1:0]   HMASTERS,
   input  logic                  HMASTLOCKS,
   input  logic                  HREADYS,
   input  logic                  active_ip,
   input  logic                  readyout_ip,
   input  logic [1:0]            resp_ip,
   output logic                  sel_ip,
   output logic [ADDR_WIDTH-1:0] addr_ip,
   output logic [1:0]            trans_ip,
   output logic                  write_ip,
   output logic [2:0]            size_ip,
   output logic [2:0]            burst_ip,
   output logic [3:0]            prot_ip,
   output logic [MASTER_W-1:0]   master_ip,
   output logic                  mastlock_ip,
   output logic                  held_tran_ip,
   output logic                  HREADYOUTS,
   output logic [1:0]            HRESPS
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;
   localparam logic [2:0] BURST_INCR   = 3'b001;
   localparam logic [1:0] RESP_OKAY    = 2'b00;

   logic                  trans_req;
   logic                  new_tran;
   logic                  accepted;
   logic                  load_reg;

   logic                  pend_tran;
   logic                  data_phase;

   logic                  reg_sel;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [1:0]            reg_trans;
   logic                  reg_write;
   logic [2:0]            reg_size;
   logic [2:0]            reg_burst;
   logic [3:0]            reg_prot;
   logic [MASTER_W-1:0]   reg_master;
   logic                  reg_mastlock;

   assign trans_req = HSELS & HTRANSS[1];
   assign new_tran  = trans_req & HREADYS;
   assign accepted  = active_ip & readyout_ip;
   // IDLE/BUSY phases are also captured so reg_trans never shows a stale request
   assign load_reg  = new_tran | (HREADYS & ~HTRANSS[1]);

   // Holding register for the full address/control set
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         reg_sel      <= 1'b0;
         reg_addr     <= '0;
         reg_trans    <= TRANS_IDLE;
         reg_write    <= 1'b0;
         reg_size     <= 3'b000;
         reg_burst    <= 3'b000;
         reg_prot     <= 4'b0000;
         reg_master   <= '0;
         reg_mastlock <= 1'b0;
      end else if (load_reg) begin
         reg_sel      <= HSELS;
         reg_addr     <= HADDRS;
         reg_trans    <= HTRANSS;
         reg_write    <= HWRITES;
         reg_size     <= HSIZES;
         reg_burst    <= HBURSTS;
         reg_prot     <= HPROTS;
         reg_master   <= HMASTERS;
         reg_mastlock <= HMASTLOCKS;
      end
   end

   // Pending flag: a new transfer that misses the grant wins over a clear
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         pend_tran <= 1'b0;
      end else if (new_tran & ~accepted) begin
         pend_tran <= 1'b1;
      end else if (accepted) begin
         pend_tran <= 1'b0;
      end
   end

   // Data-phase flag: back-to-back accepted transfers keep it set
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         data_phase <= 1'b0;
      end else if (held_tran_ip & accepted) begin
         data_phase <= 1'b1;
      end else if (readyout_ip) begin
         data_phase <= 1'b0;
      end
   end

   assign held_tran_ip = pend_tran | new_tran;

   // Address/control mux: held copy while pending, otherwise the live bus
   always_comb begin
      sel_ip      = HSELS & HREADYS;
      addr_ip     = HADDRS;
      trans_ip    = HTRANSS;
      write_ip    = HWRITES;
      size_ip     = HSIZES;
      burst_ip    = HBURSTS;
      prot_ip     = HPROTS;
      master_ip   = HMASTERS;
      mastlock_ip = HMASTLOCKS;
      if (pend_tran) begin
         sel_ip      = reg_sel;
         addr_ip     = reg_addr;
         trans_ip    = reg_trans;
         write_ip    = reg_write;
         size_ip     = reg_size;
         burst_ip    = reg_burst;
         prot_ip     = reg_prot;
         master_ip   = reg_master;
         mastlock_ip = reg_mastlock;
`ifdef AHB_INSTAGE_BURST_OVERRIDE_EN
         if (reg_trans == TRANS_SEQ) begin
            trans_ip = TRANS_NONSEQ;
            burst_ip = BURST_INCR;
         end
`endif
      end
   end

   // Master-side response: stall while pending, follow the slave in data phase
   always_comb begin
      HREADYOUTS = 1'b1;
      HRESPS     = RESP_OKAY;
      if (pend_tran) begin
         HREADYOUTS = 1'b0;
      end else if (data_phase) begin
         HREADYOUTS = readyout_ip;
      end
      if (data_phase) begin
         HRESPS = resp_ip;
      end
   end

endmodule
